// File: rtl/arith_rr_sched_if.sv
// Request, arithmetic-unit and response bundle for arith_rr_sched; slave = scheduler, master = clients + unit.
interface arith_rr_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic                     en;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*WIDTH-1:0]   req_a;
  logic [N_REQ*WIDTH-1:0]   req_b;
  logic [N_REQ*2-1:0]       req_sel;
  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic [1:0]               alu_sel;
  logic [WIDTH-1:0]         alu_r;
  logic [N_REQ-1:0]         rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_dbz;
  logic                     busy;

  modport slave (
    input  en, req_valid, req_a, req_b, req_sel, alu_r,
    output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_data, rsp_dbz, busy
  );

  modport master (
    output en, req_valid, req_a, req_b, req_sel, alu_r,
    input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_data, rsp_dbz, busy
  );
endinterface

// File: rtl/arith_rr_sched.sv
// Round-robin issue of N_REQ requesters onto one shared arithmetic unit; response LATENCY+2 cycles after grant.
// Grant is combinational (valid/ready); responses are never backpressured.
module arith_rr_sched #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  arith_rr_sched_if.slave    bus
);

  localparam int DEPTH = LATENCY + 1;

  logic [ID_W-1:0]   last_q, last_d;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;

  logic [WIDTH-1:0]  sel_a, sel_b;
  logic [1:0]        sel_op;
  logic              sel_dbz;

  logic [WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [WIDTH-1:0]  alu_b_q, alu_b_d;
  logic [1:0]        alu_sel_q, alu_sel_d;

  logic [DEPTH-1:0]  tag_vld_q;
  logic [DEPTH-1:0]  tag_dbz_q;
  logic [ID_W-1:0]   tag_id_q [DEPTH];

  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_dbz_q, rsp_dbz_d;

  // Search starts one past the last winner so every requester gets a turn within N_REQ issues.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (bus.en && !rst) begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (!gnt_any && bus.req_valid[(int'(last_q) + k) % N_REQ]) begin
          gnt_any = 1'b1;
          gnt[(int'(last_q) + k) % N_REQ] = 1'b1;
          gnt_idx = ID_W'((int'(last_q) + k) % N_REQ);
        end
      end
    end
  end

  assign bus.req_ready = gnt;

  always_comb begin
    sel_a   = bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    sel_b   = bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
    sel_op  = bus.req_sel[int'(gnt_idx)*2 +: 2];
    sel_dbz = (sel_op == 2'd3) && (sel_b == '0);

    alu_a_d   = gnt_any ? sel_a   : alu_a_q;
    alu_b_d   = gnt_any ? sel_b   : alu_b_q;
    alu_sel_d = gnt_any ? sel_op  : alu_sel_q;
    last_d    = gnt_any ? gnt_idx : last_q;
  end

  // The last tag stage lines up with alu_r; its payload is captured alongside the result.
  always_comb begin
    rsp_valid_d = '0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_dbz_d   = rsp_dbz_q;
    if (tag_vld_q[DEPTH-1]) begin
      rsp_valid_d = N_REQ'(1) << tag_id_q[DEPTH-1];
      rsp_id_d    = tag_id_q[DEPTH-1];
      rsp_data_d  = bus.alu_r;
      rsp_dbz_d   = tag_dbz_q[DEPTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= ID_W'(N_REQ - 1);
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      tag_vld_q   <= '0;
      tag_dbz_q   <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        tag_id_q[s] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_dbz_q   <= 1'b0;
    end else begin
      last_q      <= last_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      tag_vld_q   <= {tag_vld_q[DEPTH-2:0], gnt_any};
      tag_dbz_q   <= {tag_dbz_q[DEPTH-2:0], gnt_any & sel_dbz};
      tag_id_q[0] <= gnt_idx;
      for (int s = 1; s < DEPTH; s++) begin
        tag_id_q[s] <= tag_id_q[s-1];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_dbz_q   <= rsp_dbz_d;
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_dbz   = rsp_dbz_q;
  assign bus.busy      = (|tag_vld_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_arith_rr_sched.sv
// Bench for arith_rr_sched: a 2-stage arithmetic unit stand-in, a queue-based response/grant model, directed vectors and random traffic.
module tb_arith_rr_sched;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arith_rr_sched_if #(.N_REQ(N), .WIDTH(W)) bus ();

  arith_rr_sched #(.N_REQ(N), .WIDTH(W), .LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  // Shared arithmetic unit stand-in: two register stages, 32-bit truncating ops, x/0 = -1.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
    case (s)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return (b == 32'd0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
    endcase
  endfunction

  logic [31:0] alu_p1 = 32'd0;
  always @(posedge clk) begin
    alu_p1    <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);
    bus.alu_r <= alu_p1;
  end

  // Reference result in wide arithmetic, truncated to 32 bits.
  function automatic logic [31:0] ref_fn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (s)
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    r = sa * sb;
      default: r = (sb == 0) ? -64'sd1 : sa / sb;
    endcase
    return r[31:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
    logic        dbz;
  } exp_t;

  exp_t q[$];
  int   m_last = N - 1;

  // Cycle-level model: expected grant from the round-robin rule, expected response 4 cycles after handshake.
  always @(negedge clk) begin
    exp_t         e;
    bit           hit;
    int           g;
    int           idx;
    logic [N-1:0] eg;
    logic [31:0]  a, b;
    logic [1:0]   s;
    if (chk_on) begin
      chk("model busy", bus.busy, q.size() != 0);
      hit = (q.size() != 0) && (q[0].due == cyc);
      if (hit) e = q.pop_front();
      chk("model rsp_valid", bus.rsp_valid, hit ? (N'(1) << e.id) : N'(0));
      if (hit) begin
        chk("model rsp_id", bus.rsp_id, e.id);
        chk("model rsp_data", bus.rsp_data, e.data);
        chk("model rsp_dbz", bus.rsp_dbz, e.dbz);
      end
      g  = -1;
      eg = '0;
      if (bus.en && !rst) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (g < 0 && bus.req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) eg[g] = 1'b1;
      chk("model req_ready", bus.req_ready, eg);
      if (rst) begin
        q.delete();
        m_last = N - 1;
      end else if (g >= 0) begin
        a = bus.req_a[g*W +: W];
        b = bus.req_b[g*W +: W];
        s = bus.req_sel[g*2 +: 2];
        q.push_back('{cyc + 4, g, ref_fn(a, b, s), (s == 2'd3) && (b == 32'd0)});
        m_last = g;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
    bus.req_valid[i]       = v;
    bus.req_a[i*W +: W]    = a;
    bus.req_b[i*W +: W]    = b;
    bus.req_sel[i*2 +: 2]  = s;
  endtask

  task automatic chk_reset_state(input string nm);
    @(negedge clk);
    chk({nm, " alu_a"}, bus.alu_a, 32'd0);
    chk({nm, " alu_b"}, bus.alu_b, 32'd0);
    chk({nm, " alu_sel"}, bus.alu_sel, 2'd0);
    chk({nm, " rsp_valid"}, bus.rsp_valid, 4'd0);
    chk({nm, " rsp_id"}, bus.rsp_id, 2'd0);
    chk({nm, " rsp_data"}, bus.rsp_data, 32'd0);
    chk({nm, " rsp_dbz"}, bus.rsp_dbz, 1'b0);
    chk({nm, " busy"}, bus.busy, 1'b0);
    chk({nm, " req_ready"}, bus.req_ready, 4'd0);
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;
    logic [31:0] exp;
    logic        dbz;
  } vec_t;

  // One isolated request: grant same cycle, busy for 3 cycles, response in cycle h+4, idle after.
  task automatic single_op(input vec_t v);
    set_req(v.id, 1'b1, v.a, v.b, v.sel);
    @(negedge clk);
    chk("vec req_ready", bus.req_ready, N'(1) << v.id);
    tick();
    set_req(v.id, 1'b0, v.a, v.b, v.sel);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("vec busy inflight", bus.busy, 1'b1);
      chk("vec early rsp", bus.rsp_valid, 4'd0);
    end
    @(negedge clk);
    chk("vec rsp_valid", bus.rsp_valid, N'(1) << v.id);
    chk("vec rsp_id", bus.rsp_id, v.id);
    chk("vec rsp_data", bus.rsp_data, v.exp);
    chk("vec rsp_dbz", bus.rsp_dbz, v.dbz);
    @(negedge clk);
    chk("vec rsp done", bus.rsp_valid, 4'd0);
    chk("vec busy after", bus.busy, 1'b0);
    tick();
  endtask

  vec_t         tv[12];
  logic [31:0]  exp4[4];
  logic [N-1:0] hs;
  int           waitc;
  logic [31:0]  ra, rb;
  logic [1:0]   rs;

  initial begin
    bus.en        = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;

    tv[0]  = '{2, 32'd7,          32'd5,          2'd0, 32'd12,         1'b0};
    tv[1]  = '{0, 32'd3,          32'd10,         2'd1, 32'hFFFF_FFF9,  1'b0};
    tv[2]  = '{1, 32'd6,          32'd7,          2'd2, 32'd42,         1'b0};
    tv[3]  = '{2, 32'd100,        32'd7,          2'd3, 32'd14,         1'b0};
    tv[4]  = '{3, 32'd1,          32'd1,          2'd0, 32'd2,          1'b0};
    tv[5]  = '{1, 32'd9,          32'd0,          2'd3, 32'hFFFF_FFFF,  1'b1};
    tv[6]  = '{1, 32'd9,          32'd3,          2'd3, 32'd3,          1'b0};
    tv[7]  = '{0, 32'hFFFF_FFF9,  32'd2,          2'd3, 32'hFFFF_FFFD,  1'b0};
    tv[8]  = '{3, 32'h0001_0000,  32'h0001_0000,  2'd2, 32'd0,          1'b0};
    tv[9]  = '{2, 32'h7FFF_FFFF,  32'd1,          2'd0, 32'h8000_0000,  1'b0};
    tv[10] = '{0, 32'd0,          32'd1,          2'd1, 32'hFFFF_FFFF,  1'b0};
    tv[11] = '{3, 32'd0,          32'd0,          2'd2, 32'd0,          1'b0};
    exp4   = '{32'hFFFF_FFF9, 32'd42, 32'd14, 32'd2};

    rst = 1'b1;
    tick();
    chk_on = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("reset");
    tick();

    for (int i = 0; i < 12; i++) single_op(tv[i]);

    // All four contending: fresh pointer means grants 0,1,2,3 then in-order responses.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 32'd3,   32'd10, 2'd1);
    set_req(1, 1'b1, 32'd6,   32'd7,  2'd2);
    set_req(2, 1'b1, 32'd100, 32'd7,  2'd3);
    set_req(3, 1'b1, 32'd1,   32'd1,  2'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rr grant order", bus.req_ready, N'(1) << c);
      tick();
      bus.req_valid[c] = 1'b0;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rr rsp_valid", bus.rsp_valid, N'(1) << c);
      chk("rr rsp_id", bus.rsp_id, c);
      chk("rr rsp_data", bus.rsp_data, exp4[c]);
    end
    tick();

    // Fairness: req0 held valid, req3 joins once.
    set_req(0, 1'b1, 32'd1, 32'd1, 2'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("fair solo req0", bus.req_ready, 4'b0001);
      tick();
    end
    set_req(3, 1'b1, 32'd5, 32'd5, 2'd2);
    waitc = 0;
    while (waitc < N) begin
      @(negedge clk);
      if (bus.req_ready[3]) break;
      tick();
      waitc++;
    end
    chk("fair req3 within N", waitc < N, 1'b1);
    tick();
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    chk("fair req0 not starved", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid[0] = 1'b0;
    repeat (6) tick();

    // en low: grants stop, issued op still returns, grants resume after last winner.
    set_req(2, 1'b1, 32'd10, 32'd3, 2'd1);
    @(negedge clk);
    chk("en issue req2", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid[2] = 1'b0;
    bus.en = 1'b0;
    set_req(0, 1'b1, 32'd4, 32'd4, 2'd2);
    set_req(3, 1'b1, 32'd8, 32'd2, 2'd3);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("en low no grant", bus.req_ready, 4'd0);
      tick();
    end
    @(negedge clk);
    chk("en low no grant", bus.req_ready, 4'd0);
    chk("en low drain rsp_valid", bus.rsp_valid, 4'b0100);
    chk("en low drain rsp_data", bus.rsp_data, 32'd7);
    tick();
    bus.en = 1'b1;
    @(negedge clk);
    chk("en resume after last", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    chk("en resume wrap", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid[0] = 1'b0;
    repeat (6) tick();

    // Reset with two ops in flight: nothing returns, pointer back to N-1.
    set_req(1, 1'b1, 32'd2, 32'd3, 2'd0);
    @(negedge clk);
    chk("rst issue req1", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid[1] = 1'b0;
    set_req(2, 1'b1, 32'd4, 32'd5, 2'd2);
    @(negedge clk);
    chk("rst issue req2", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid[2] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("midrst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst no rsp", bus.rsp_valid, 4'd0);
    end
    tick();
    set_req(0, 1'b1, 32'd1, 32'd2, 2'd0);
    set_req(1, 1'b1, 32'd3, 32'd4, 2'd0);
    @(negedge clk);
    chk("post-rst req0 first", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    chk("post-rst req1 next", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid[1] = 1'b0;
    repeat (6) tick();

    // Random traffic against the model, with occasional en drops and resets.
    for (int it = 0; it < 1000; it++) begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      tick();
      rst    = ($urandom_range(0, 199) == 0);
      bus.en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) begin
        if (hs[i] || !bus.req_valid[i]) begin
          ra = $urandom;
          rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
          rs = 2'($urandom_range(0, 3));
          if (rs == 2'd3 && rb != 32'd0 && $urandom_range(0, 1) == 1) rb = $urandom_range(1, 20);
          if (rs == 2'd3 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
          set_req(i, 1'($urandom_range(0, 1)), ra, rb, rs);
        end
      end
    end
    tick();
    rst = 1'b0;
    bus.en = 1'b1;
    bus.req_valid = '0;
    repeat (8) tick();
    @(negedge clk);
    chk("drain no lost rsp", q.size(), 0);
    chk("drain busy", bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
